// File: rtl/dense1_deserial_pkg.sv
// Shared parameters for the dense-layer serial path: word geometry of the
// first fully-connected layer and the receive-side state encoding.
package dense1_deserial_pkg;

  localparam int N_WORDS_DENSE1 = 120;
  localparam int DATA_WIDTH     = 16;
  localparam int CNT_WIDTH      = 7;

  // Receive-side frame state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : dense1_deserial_pkg

// File: rtl/dense1_deserial_if.sv
// Framed word stream in, packed dense vector out with a valid/ack hold
// handshake. The master modport is the side that sends words and consumes
// the vector; the slave modport is the deserializer.
interface dense1_deserial_if #(
  parameter int N_WORDS    = dense1_deserial_pkg::N_WORDS_DENSE1,
  parameter int DATA_WIDTH = dense1_deserial_pkg::DATA_WIDTH,
  parameter int CNT_WIDTH  = dense1_deserial_pkg::CNT_WIDTH
);

  logic                          frame_start;
  logic                          valid;
  logic [DATA_WIDTH-1:0]         data_in;
  logic                          frame_end;
  logic                          out_ack;
  logic [N_WORDS*DATA_WIDTH-1:0] dense_out;
  logic                          out_valid;
  logic                          frame_err;
  logic                          overrun;
  logic [CNT_WIDTH-1:0]          word_cnt;

  modport master (
    output frame_start, valid, data_in, frame_end, out_ack,
    input  dense_out, out_valid, frame_err, overrun, word_cnt
  );

  modport slave (
    input  frame_start, valid, data_in, frame_end, out_ack,
    output dense_out, out_valid, frame_err, overrun, word_cnt
  );

endinterface : dense1_deserial_if

// File: rtl/dense1_deserial.sv
// Receive-side deserializer: packs N_WORDS framed signed words into one
// parallel vector (first word in the LSBs) and holds it until acknowledged.
// Malformed frames pulse frame_err; words arriving while a full vector is
// held are dropped and pulse overrun.
module dense1_deserial #(
  parameter int N_WORDS    = dense1_deserial_pkg::N_WORDS_DENSE1,
  parameter int DATA_WIDTH = dense1_deserial_pkg::DATA_WIDTH,
  parameter int CNT_WIDTH  = dense1_deserial_pkg::CNT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  dense1_deserial_if.slave   bus
);

  import dense1_deserial_pkg::*;

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(N_WORDS - 1);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(N_WORDS);

  state_t                state;
  logic [CNT_WIDTH-1:0]  word_cnt_q;
  logic                  out_valid_q;
  logic                  frame_err_q;
  logic                  overrun_q;

  logic [DATA_WIDTH-1:0] slots [N_WORDS];

  logic                  wr_en;
  logic [CNT_WIDTH-1:0]  wr_idx;

  // Decide whether this cycle's word is stored and into which slot.
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = '0;
    case (state)
      IDLE: wr_en = bus.frame_start && bus.valid;
      RECV: begin
        wr_en  = bus.valid;
        wr_idx = bus.frame_start ? '0 : word_cnt_q;
      end
      DONE: wr_en = bus.out_ack && bus.frame_start && bus.valid;
      default: wr_en = 1'b0;
    endcase
  end

  // Word storage; bit-exact copy of the incoming word into its slot.
  // NOTE: the slot array is reset because a reset must clear dense_out
  // immediately; without that requirement it could be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_WORDS; i++) slots[i] <= '0;
    end else if (wr_en) begin
      slots[wr_idx] <= bus.data_in;
    end
  end

  // Frame state machine with registered handshake and error pulses.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      word_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.frame_start) begin
            state      <= RECV;
            word_cnt_q <= CNT_WIDTH'(bus.valid);
          end
        end

        RECV: begin
          if (bus.frame_start) begin
            // Restart: the old partial frame is abandoned.
            frame_err_q <= 1'b1;
            word_cnt_q  <= CNT_WIDTH'(bus.valid);
          end else if (bus.valid && word_cnt_q == LAST_IDX) begin
            // Final word completes the frame; a coincident frame_end is fine.
            state       <= DONE;
            word_cnt_q  <= FULL_CNT;
            out_valid_q <= 1'b1;
          end else if (bus.frame_end) begin
            // Early end: partial data stays visible but is never validated.
            frame_err_q <= 1'b1;
            state       <= IDLE;
            word_cnt_q  <= '0;
          end else if (bus.valid) begin
            word_cnt_q  <= word_cnt_q + CNT_WIDTH'(1);
          end
        end

        DONE: begin
          if (bus.out_ack) begin
            out_valid_q <= 1'b0;
            if (bus.frame_start) begin
              // Ack and new frame together: no bubble between frames.
              state      <= RECV;
              word_cnt_q <= CNT_WIDTH'(bus.valid);
            end else begin
              // A bare word in the ack cycle still hits the held vector.
              state      <= IDLE;
              word_cnt_q <= '0;
              overrun_q  <= bus.valid;
            end
          end else if (bus.valid || bus.frame_start) begin
            overrun_q <= 1'b1;
          end
        end

        default: begin
          state      <= IDLE;
          word_cnt_q <= '0;
        end
      endcase
    end
  end

  // Flatten the slot array onto the packed output, slot 0 in the LSBs.
  for (genvar i = 0; i < N_WORDS; i++) begin : g_flat
    assign bus.dense_out[i*DATA_WIDTH +: DATA_WIDTH] = slots[i];
  end

  assign bus.out_valid = out_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.word_cnt  = word_cnt_q;

endmodule : dense1_deserial
